// File: rtl/wshb_slave_mem.sv
// Wishbone B3 classic-cycle slave memory: byte-lane writes, registered reads, wait states, error reply.
// Define WSHB_SLV_RTY_EN to answer every RTY_PERIOD-th good request with a retry termination.
module wshb_slave_mem #(
  parameter int unsigned           ADDR_WIDTH  = 32,
  parameter int unsigned           DATA_WIDTH  = 32,
  parameter int unsigned           MEM_DEPTH   = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
  parameter int unsigned           WAIT_STATES = 0,
  parameter int unsigned           RTY_PERIOD  = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   adr_i,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  input  logic [DATA_WIDTH/8-1:0] sel_i,
  input  logic                    cyc_i,
  input  logic                    stb_i,
  input  logic                    we_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    ack_o,
  output logic                    err_o,
  output logic                    rty_o
);

  localparam int unsigned Bytes = DATA_WIDTH / 8;
  localparam int unsigned Lsb   = $clog2(Bytes);
  localparam int unsigned IdxW  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] AlignMask = ADDR_WIDTH'(Bytes - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e                  state_q;
  logic [3:0]              cnt_q;
  logic [ADDR_WIDTH-1:0]   adr_q;
  logic [DATA_WIDTH-1:0]   dat_q;
  logic [Bytes-1:0]        sel_q;
  logic                    we_q;
  logic                    ack_q, err_q, rty_q;
  logic [DATA_WIDTH-1:0]   rdat_q;
  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic                    req;
  logic [ADDR_WIDTH-1:0]   cur_adr;
  logic [DATA_WIDTH-1:0]   cur_dat;
  logic [Bytes-1:0]        cur_sel;
  logic                    cur_we;
  logic [ADDR_WIDTH-1:0]   offs;
  logic [ADDR_WIDTH-1:0]   idx;
  logic [IdxW-1:0]         mem_idx;
  logic                    bad;
  logic                    go_resp;
  logic                    retry_hit;
  logic                    access;

  assign req = cyc_i & stb_i;

  // Live bus values are used in IDLE; once a request is accepted the latched copy is authoritative.
  always_comb begin
    cur_adr = adr_q;
    cur_dat = dat_q;
    cur_sel = sel_q;
    cur_we  = we_q;
    if (state_q == StIdle) begin
      cur_adr = adr_i;
      cur_dat = dat_i;
      cur_sel = sel_i;
      cur_we  = we_i;
    end
  end

  assign offs    = cur_adr - BASE_ADDR;
  assign idx     = offs >> Lsb;
  assign mem_idx = idx[IdxW-1:0];
  assign bad     = (cur_adr < BASE_ADDR) | (idx >= ADDR_WIDTH'(MEM_DEPTH)) |
                   ((offs & AlignMask) != '0);

  assign go_resp = req & (((state_q == StIdle) & (WAIT_STATES == 0)) |
                          ((state_q == StWait) & (cnt_q == 4'd0)));
  assign access  = go_resp & ~bad & ~retry_hit;

`ifdef WSHB_SLV_RTY_EN
  logic [3:0] rcnt_q;

  assign retry_hit = (rcnt_q == 4'(RTY_PERIOD - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rcnt_q <= '0;
    end else if (go_resp && !bad) begin
      rcnt_q <= retry_hit ? 4'd0 : rcnt_q + 4'd1;
    end
  end
`else
  // Retry disabled: RTY_PERIOD has no effect in this build.
  assign retry_hit = 1'b0 & (RTY_PERIOD > 1);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      adr_q   <= '0;
      dat_q   <= '0;
      sel_q   <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      rty_q   <= 1'b0;
      rdat_q  <= '0;
    end else begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rty_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (req) begin
            adr_q <= adr_i;
            dat_q <= dat_i;
            sel_q <= sel_i;
            we_q  <= we_i;
            if (WAIT_STATES == 0) begin
              state_q <= StResp;
            end else begin
              cnt_q   <= 4'(WAIT_STATES - 1);
              state_q <= StWait;
            end
          end
        end
        StWait: begin
          if (!req) begin
            state_q <= StIdle;
          end else if (cnt_q == 4'd0) begin
            state_q <= StResp;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        StResp: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
      if (go_resp) begin
        if (bad) begin
          err_q <= 1'b1;
        end else if (retry_hit) begin
          rty_q <= 1'b1;
        end else begin
          ack_q <= 1'b1;
        end
      end
      if (access && !cur_we) begin
        rdat_q <= mem[mem_idx];
      end
    end
  end

  // Write commits on the edge entering RESP, so a following read always sees it.
  always_ff @(posedge clk) begin
    if (rst_n && access && cur_we) begin
      for (int unsigned b = 0; b < Bytes; b++) begin
        if (cur_sel[b]) begin
          mem[mem_idx][8*b +: 8] <= cur_dat[8*b +: 8];
        end
      end
    end
  end

  assign dat_o = rdat_q;
  assign ack_o = ack_q;
  assign err_o = err_q;
  assign rty_o = rty_q;

endmodule

// File: tb/tb_wshb_slave_mem.sv
// Bench for wshb_slave_mem: directed and random transfers against a word/byte-mask reference model.
// Two instances: zero wait states at base 0, and three wait states at base 0x100 with a small depth.
module tb_wshb_slave_mem;

`ifdef WSHB_SLV_RTY_EN
  localparam bit RtyEn = 1'b1;
`else
  localparam bit RtyEn = 1'b0;
`endif
  localparam int RtyPeriod     = 4;
  localparam int TimeoutCycles = 40;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] adr   [2];
  logic [31:0] dat_w [2];
  logic [31:0] dat_r [2];
  logic [3:0]  sel   [2];
  logic        cyc   [2];
  logic        stb   [2];
  logic        we    [2];
  logic        ack   [2];
  logic        err   [2];
  logic        rty   [2];

  wshb_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(1024), .BASE_ADDR(32'h0),
    .WAIT_STATES(0), .RTY_PERIOD(RtyPeriod)
  ) u_dut0 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr[0]), .dat_i(dat_w[0]), .sel_i(sel[0]),
    .cyc_i(cyc[0]), .stb_i(stb[0]), .we_i(we[0]), .dat_o(dat_r[0]),
    .ack_o(ack[0]), .err_o(err[0]), .rty_o(rty[0])
  );

  wshb_slave_mem #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .MEM_DEPTH(64), .BASE_ADDR(32'h100),
    .WAIT_STATES(3), .RTY_PERIOD(RtyPeriod)
  ) u_dut3 (
    .clk(clk), .rst_n(rst_n), .adr_i(adr[1]), .dat_i(dat_w[1]), .sel_i(sel[1]),
    .cyc_i(cyc[1]), .stb_i(stb[1]), .we_i(we[1]), .dat_o(dat_r[1]),
    .ack_o(ack[1]), .err_o(err[1]), .rty_o(rty[1])
  );

  // Reference model: per-instance geometry, word contents and which bytes are known.
  int unsigned base_m  [2] = '{32'h0, 32'h100};
  int unsigned depth_m [2] = '{1024, 64};
  int          ws_m    [2] = '{0, 3};
  logic [31:0] mm      [2][1024];
  logic [3:0]  kn      [2][1024];
  int          rcnt    [2];
  logic [31:0] exp_dat [2];
  logic [31:0] exp_msk [2];

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] bmask(input logic [3:0] k);
    logic [31:0] m;
    for (int b = 0; b < 4; b++) m[8*b +: 8] = {8{k[b]}};
    return m;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      rcnt[d]    = 0;
      exp_dat[d] = 32'h0;
      exp_msk[d] = 32'hFFFF_FFFF;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Drive one request (called #1 after an edge) and wait for any termination.
  task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [31:0] wd,
                      input logic [3:0] s, output int term, output int lat,
                      output logic [31:0] rd, output int nterm);
    adr[d] = a; dat_w[d] = wd; sel[d] = s; we[d] = w;
    cyc[d] = 1'b1; stb[d] = 1'b1;
    term = 0; lat = 0; nterm = 0;
    while (term == 0 && lat < TimeoutCycles) begin
      @(posedge clk);
      #1;
      lat++;
      nterm = int'(ack[d]) + int'(err[d]) + int'(rty[d]);
      if (ack[d]) term = 1;
      else if (err[d]) term = 2;
      else if (rty[d]) term = 3;
    end
    rd = dat_r[d];
    cyc[d] = 1'b0; stb[d] = 1'b0;
  endtask

  // Predict termination/data from address rules, run the transfer, compare.
  task automatic check_xfer(input string tag, input int d, input logic [31:0] a, input logic w,
                            input logic [31:0] wd, input logic [3:0] s, input bit b2b,
                            output int term);
    int          t_exp, lat, nterm, idx;
    logic [31:0] rd;
    longint      offs;
    bit          isbad;
    offs  = longint'(a) - longint'(base_m[d]);
    isbad = (offs < 0) || (offs % 4 != 0) || (offs / 4 >= longint'(depth_m[d]));
    idx   = isbad ? 0 : int'(offs / 4);
    if (isbad) begin
      t_exp = 2;
    end else if (RtyEn && rcnt[d] == RtyPeriod - 1) begin
      t_exp   = 3;
      rcnt[d] = 0;
    end else begin
      t_exp = 1;
      if (RtyEn) rcnt[d]++;
      if (w) begin
        for (int b = 0; b < 4; b++) begin
          if (s[b]) begin
            mm[d][idx][8*b +: 8] = wd[8*b +: 8];
            kn[d][idx][b] = 1'b1;
          end
        end
      end else begin
        exp_dat[d] = mm[d][idx];
        exp_msk[d] = bmask(kn[d][idx]);
      end
    end
    xfer(d, a, w, wd, s, term, lat, rd, nterm);
    chk({tag, "_term"}, 32'(term), 32'(t_exp));
    chk({tag, "_lat"}, 32'(lat), 32'(ws_m[d] + 1 + int'(b2b)));
    chk({tag, "_onehot"}, 32'(nterm), 32'd1);
    chk({tag, "_data"}, rd & exp_msk[d], exp_dat[d] & exp_msk[d]);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int term;
    int nrty;
    bit quiet;
    for (int d = 0; d < 2; d++) begin
      adr[d] = '0; dat_w[d] = '0; sel[d] = '0; cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
      for (int i = 0; i < 1024; i++) begin
        mm[d][i] = '0;
        kn[d][i] = '0;
      end
    end
    do_reset();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_term%0d", d), {29'd0, ack[d], err[d], rty[d]}, 32'd0);
      chk($sformatf("rst_dat%0d", d), dat_r[d], 32'd0);
    end

    // Single-cycle write then read.
    idle(1);
    check_xfer("wr_10", 0, 32'h10, 1'b1, 32'hDEAD_BEEF, 4'hF, 1'b0, term);
    idle(1);
    check_xfer("rd_10", 0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b0, term);

    // Byte lanes and an empty lane mask.
    idle(1);
    check_xfer("wr_20", 0, 32'h20, 1'b1, 32'hFFFF_FFFF, 4'hF, 1'b0, term);
    check_xfer("wr_20_lanes", 0, 32'h20, 1'b1, 32'h1122_3344, 4'h5, 1'b1, term);
    check_xfer("rd_20", 0, 32'h20, 1'b0, 32'h0, 4'h0, 1'b1, term);
    check_xfer("wr_10_nosel", 0, 32'h10, 1'b1, 32'h0BAD_0BAD, 4'h0, 1'b1, term);
    check_xfer("rd_10_again", 0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b1, term);

    // Error terminations: misaligned, past the end, below base.
    idle(1);
    check_xfer("err_mis", 0, 32'h1002, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b0, term);
    check_xfer("err_end", 0, 32'h1000, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, term);
    check_xfer("err_mis_in", 0, 32'h12, 1'b1, 32'hCAFE_F00D, 4'hF, 1'b1, term);
    check_xfer("rd_10_post_err", 0, 32'h10, 1'b0, 32'h0, 4'h0, 1'b1, term);
    check_xfer("err_below", 1, 32'hFC, 1'b1, 32'h1234_5678, 4'hF, 1'b0, term);
    check_xfer("err_end3", 1, 32'h200, 1'b0, 32'h0, 4'h0, 1'b1, term);

    // Wait states, then an abort after two cycles.
    idle(1);
    check_xfer("ws_wr", 1, 32'h108, 1'b1, 32'h5A5A_0F0F, 4'hF, 1'b0, term);
    check_xfer("ws_rd", 1, 32'h108, 1'b0, 32'h0, 4'h0, 1'b1, term);
    idle(1);
    adr[1] = 32'h108; dat_w[1] = 32'hFFFF_0000; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    idle(2);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (ack[1] || err[1] || rty[1]) quiet = 1'b0;
    end
    chk("abort_quiet", 32'(quiet), 32'd1);
    check_xfer("abort_rd", 1, 32'h108, 1'b0, 32'h0, 4'h0, 1'b0, term);

    // Eight back-to-back writes with the strobe held, then read them back.
    idle(1);
    for (int i = 0; i < 8; i++) begin
      check_xfer($sformatf("b2b_wr%0d", i), 0, 32'(32'h40 + 4 * i), 1'b1,
                 32'(32'hA000_0000 + i * 32'h0101), 4'hF, i > 0, term);
    end
    for (int i = 0; i < 8; i++) begin
      check_xfer($sformatf("b2b_rd%0d", i), 0, 32'(32'h40 + 4 * i), 1'b0, 32'h0, 4'h0, 1'b1,
                 term);
    end

    // From reset, eight reads: with retry enabled the 4th and 8th are retried.
    idle(1);
    do_reset();
    nrty = 0;
    for (int i = 0; i < 8; i++) begin
      check_xfer($sformatf("rty_rd%0d", i), 0, 32'(32'h40 + 4 * i), 1'b0, 32'h0, 4'h0, i > 0,
                 term);
      if (term == 3) nrty++;
    end
    chk("rty_count", 32'(nrty), RtyEn ? 32'd2 : 32'd0);

    // Reset asserted while a write is still in its wait states: the write must be dropped.
    idle(1);
    check_xfer("mr_pre", 1, 32'h104, 1'b1, 32'h1357_9BDF, 4'hF, 1'b0, term);
    idle(1);
    adr[1] = 32'h104; dat_w[1] = 32'hA5A5_A5A5; sel[1] = 4'hF; we[1] = 1'b1;
    cyc[1] = 1'b1; stb[1] = 1'b1;
    idle(2);
    rst_n = 1'b0;
    idle(1);
    stb[1] = 1'b0; cyc[1] = 1'b0;
    chk("mr_term", {29'd0, ack[1], err[1], rty[1]}, 32'd0);
    rst_n = 1'b1;
    model_reset();
    quiet = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      if (ack[1] || err[1] || rty[1]) quiet = 1'b0;
    end
    chk("mr_quiet", 32'(quiet), 32'd1);
    check_xfer("mr_rd", 1, 32'h104, 1'b0, 32'h0, 4'h0, 1'b0, term);

    // Random mix of reads, partial writes and bad addresses on both instances.
    for (int d = 0; d < 2; d++) begin
      idle(2);
      for (int i = 0; i < 150; i++) begin
        bit          b2b;
        logic [31:0] a;
        b2b = (i > 0) && ($urandom_range(0, 1) == 1);
        if (!b2b) idle(int'($urandom_range(1, 2)));
        a = 32'(base_m[d] + 4 * $urandom_range(0, 31));
        case ($urandom_range(0, 11))
          0: a = 32'(a + $urandom_range(1, 3));
          1: a = 32'(base_m[d] + 4 * depth_m[d] + 4 * $urandom_range(0, 7));
          2: a = (d == 1) ? 32'(base_m[d] - 4) : 32'h8000_0000;
          default: ;
        endcase
        check_xfer($sformatf("rand%0d_%0d", d, i), d, a, $urandom_range(0, 1) == 1, $urandom,
                   4'($urandom_range(0, 15)), b2b, term);
      end
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
